// File: rtl/cbd_sampler_stream_if.sv
// Stream bundle for the CBD sampler: PRF rate blocks in, coefficient beats out.
// master = sampler side, slave = PRF engine / downstream datapath side.
interface cbd_sampler_stream_if #(
   parameter int unsigned N_POLY_MAX = 8,
   parameter int unsigned LANES      = 8,
   parameter int unsigned COEFF_W    = 8,
   parameter int unsigned RATE       = 1088
);
   localparam int unsigned PolyW = $clog2(N_POLY_MAX);

   logic                       blk_valid;
   logic [RATE-1:0]            blk_data;
   logic                       blk_ready;

   logic                       coef_valid;
   logic [LANES*COEFF_W-1:0]   coef_data;
   logic [PolyW-1:0]           coef_poly;
   logic                       coef_last;
   logic                       coef_ready;

   modport master (
      input  blk_valid,
      input  blk_data,
      output blk_ready,
      output coef_valid,
      output coef_data,
      output coef_poly,
      output coef_last,
      input  coef_ready
   );

   modport slave (
      output blk_valid,
      output blk_data,
      input  blk_ready,
      input  coef_valid,
      input  coef_data,
      input  coef_poly,
      input  coef_last,
      output coef_ready
   );
endinterface

// File: rtl/cbd_sampler_stream.sv
// Centred-binomial (eta 2/3) sampler turning a SHAKE256 PRF squeeze stream into coefficient beats.
// Define CBD_MODQ_EN to emit coefficients as unsigned residues in [0, 3328] instead of signed.
module cbd_sampler_stream #(
   parameter int unsigned N_POLY_MAX = 8,
   parameter int unsigned LANES      = 8,
   parameter int unsigned COEFF_W    = 8,
   parameter int unsigned RATE       = 1088
) (
   input  logic                              clk_i,
   input  logic                              rst_n_i,
   input  logic                              run_i,
   input  logic                              eta_i,
   input  logic [$clog2(N_POLY_MAX+1)-1:0]   n_poly_i,
   input  logic [7:0]                        nonce_base_i,
   output logic                              prf_start_o,
   output logic [7:0]                        nonce_o,
   output logic                              busy_o,
   output logic                              done_o,
   cbd_sampler_stream_if.master              bus
);
   localparam int unsigned NW    = $clog2(N_POLY_MAX+1);
   localparam int unsigned PW    = $clog2(N_POLY_MAX);
   localparam int unsigned W2    = 4 * LANES;
   localparam int unsigned W3    = 6 * LANES;
   localparam int unsigned BUF_W = RATE + W3 - 1;
   localparam int unsigned AW    = $clog2(BUF_W + 1);
   localparam int unsigned BEATS = 256 / LANES;
   localparam int unsigned BW    = $clog2(BEATS);

   localparam logic [1:0] StIdle  = 2'd0;
   localparam logic [1:0] StStart = 2'd1;
   localparam logic [1:0] StRun   = 2'd2;

   logic [1:0]       state_q,  state_d;
   logic             eta_q,    eta_d;
   logic [NW-1:0]    n_poly_q, n_poly_d;
   logic [PW-1:0]    poly_q,   poly_d;
   logic [7:0]       nonce_q,  nonce_d;
   logic [BUF_W-1:0] buf_q,    buf_d;
   logic [AW-1:0]    avail_q,  avail_d;
   logic [1:0]       taken_q,  taken_d;
   logic [BW-1:0]    beat_q,   beat_d;
   logic             coef_valid_q, coef_valid_d;
   logic             done_q,   done_d;

   logic [AW-1:0]    w_cur;
   logic [1:0]       blk_need;
   logic             blk_ready;
   logic             blk_hs;
   logic             beat_hs;
   logic             last_beat;
   logic             last_poly;

   assign w_cur     = eta_q ? AW'(W3) : AW'(W2);
   assign blk_need  = eta_q ? 2'd2 : 2'd1;
   // Only refill when no complete beat is buffered, so unsent bits are never overwritten.
   assign blk_ready = (state_q == StRun) && (avail_q < w_cur) && (taken_q < blk_need);
   assign blk_hs    = bus.blk_valid && blk_ready;
   assign beat_hs   = coef_valid_q && bus.coef_ready;
   assign last_beat = (beat_q == BW'(BEATS - 1));
   assign last_poly = ((NW'(poly_q) + NW'(1)) == n_poly_q);

   always_comb begin
      state_d  = state_q;
      eta_d    = eta_q;
      n_poly_d = n_poly_q;
      poly_d   = poly_q;
      nonce_d  = nonce_q;
      buf_d    = buf_q;
      avail_d  = avail_q;
      taken_d  = taken_q;
      beat_d   = beat_q;
      done_d   = 1'b0;
      case (state_q)
         StIdle: begin
            if (run_i) begin
               if (n_poly_i == '0) begin
                  done_d = 1'b1;
               end else begin
                  state_d  = StStart;
                  eta_d    = eta_i;
                  n_poly_d = n_poly_i;
                  nonce_d  = nonce_base_i;
                  poly_d   = '0;
               end
            end
         end
         StStart: begin
            state_d = StRun;
         end
         StRun: begin
            if (blk_hs) begin
               // Upper buffer bits are always zero, so OR-ing places the block above avail.
               buf_d   = buf_q | ({{(BUF_W - RATE){1'b0}}, bus.blk_data} << avail_q);
               avail_d = avail_q + AW'(RATE);
               taken_d = taken_q + 2'd1;
            end else if (beat_hs) begin
               if (last_beat) begin
                  buf_d   = '0;
                  avail_d = '0;
                  taken_d = '0;
                  beat_d  = '0;
                  if (last_poly) begin
                     state_d = StIdle;
                     done_d  = 1'b1;
                  end else begin
                     state_d = StStart;
                     poly_d  = poly_q + PW'(1);
                     nonce_d = nonce_q + 8'd1;
                  end
               end else begin
                  buf_d   = eta_q ? (buf_q >> W3) : (buf_q >> W2);
                  avail_d = avail_q - w_cur;
                  beat_d  = beat_q + BW'(1);
               end
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   assign coef_valid_d = (state_d == StRun) && (avail_d >= w_cur);

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q      <= StIdle;
         eta_q        <= 1'b0;
         n_poly_q     <= '0;
         poly_q       <= '0;
         nonce_q      <= '0;
         buf_q        <= '0;
         avail_q      <= '0;
         taken_q      <= '0;
         beat_q       <= '0;
         coef_valid_q <= 1'b0;
         done_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         eta_q        <= eta_d;
         n_poly_q     <= n_poly_d;
         poly_q       <= poly_d;
         nonce_q      <= nonce_d;
         buf_q        <= buf_d;
         avail_q      <= avail_d;
         taken_q      <= taken_d;
         beat_q       <= beat_d;
         coef_valid_q <= coef_valid_d;
         done_q       <= done_d;
      end
   end

   logic [LANES*COEFF_W-1:0] coef_data;
   logic [2:0]               xb, yb, xc, yc;
   logic [3:0]               diff;
   logic [COEFF_W-1:0]       sval;

   // The buffer holds still while a beat waits, so the decoded lanes stay stable under stall.
   always_comb begin
      coef_data = '0;
      xb        = '0;
      yb        = '0;
      xc        = '0;
      yc        = '0;
      diff      = '0;
      sval      = '0;
      for (int unsigned j = 0; j < LANES; j++) begin
         if (eta_q) begin
            xb = buf_q[6*j +: 3];
            yb = buf_q[6*j+3 +: 3];
         end else begin
            xb = {1'b0, buf_q[4*j +: 2]};
            yb = {1'b0, buf_q[4*j+2 +: 2]};
         end
         xc   = 3'(xb[0]) + 3'(xb[1]) + 3'(xb[2]);
         yc   = 3'(yb[0]) + 3'(yb[1]) + 3'(yb[2]);
         diff = {1'b0, xc} - {1'b0, yc};
         sval = {{(COEFF_W - 4){diff[3]}}, diff};
`ifdef CBD_MODQ_EN
         if (diff[3]) begin
            sval = sval + COEFF_W'(3329);
         end
`endif
         coef_data[j*COEFF_W +: COEFF_W] = sval;
      end
   end

   assign bus.blk_ready  = blk_ready;
   assign bus.coef_valid = coef_valid_q;
   assign bus.coef_data  = coef_data;
   assign bus.coef_poly  = poly_q;
   assign bus.coef_last  = coef_valid_q && last_beat;

   assign prf_start_o = (state_q == StStart);
   assign nonce_o     = nonce_q;
   assign busy_o      = (state_q != StIdle);
   assign done_o      = done_q;
endmodule
